// File: rtl/mlp_pkg.sv
// Shared definitions for the MLP tile engine.
//   state_e     : top-level sequencing states of the engine
//   ACT_W/ACC_W : activation/weight width and accumulator width
//   relu_sat_act: clamps a rounded requant value to the [0, 127] int8 range
package mlp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_X,
    LOAD_W,
    LOAD_B,
    BIAS,
    MAC,
    DRAIN,
    DONE
  } state_e;

  localparam int ACT_W = 8;
  localparam int ACC_W = 32;

  // ReLU followed by saturation to the positive int8 range.
  function automatic logic [ACT_W-1:0] relu_sat_act(input logic signed [63:0] r);
    if (r < 64'sd0) begin
      return '0;
    end else if (r > 64'sd127) begin
      return 8'd127;
    end else begin
      return r[ACT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/mlp_requant.sv
// Combinational requantiser for one accumulator value.
//   acc_i   : signed 32-bit accumulator
//   scale_i : unsigned multiplier, 2^SHIFT represents x1.0
//   mode_i  : 0 = scaled/rounded/ReLU/saturated int8, 1 = raw accumulator
//   ofmap_o : 32-bit result word (int8 results are zero-extended)
module mlp_requant
  import mlp_pkg::*;
#(
  parameter int SCALE_W = 12,
  parameter int SHIFT   = 8
) (
  input  logic signed [ACC_W-1:0]   acc_i,
  input  logic        [SCALE_W-1:0] scale_i,
  input  logic                      mode_i,
  output logic        [31:0]        ofmap_o
);

  localparam int PW = ACC_W + SCALE_W + 1;
  localparam logic signed [PW-1:0] HALF = PW'(1) << (SHIFT - 1);

  // Round half up, then arithmetic shift back to integer scale.
  function automatic logic signed [PW-1:0] round_shift(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] s;
    s = p + HALF;
    return s >>> SHIFT;
  endfunction

  logic signed [PW-1:0]    prod;
  logic signed [PW-1:0]    rnd;
  logic        [ACT_W-1:0] y;

  always_comb begin
    // Scale is zero-extended so the product stays signed x unsigned.
    prod    = PW'(acc_i) * PW'($signed({1'b0, scale_i}));
    rnd     = round_shift(prod);
    y       = relu_sat_act(64'(rnd));
    ofmap_o = mode_i ? acc_i : {{(32-ACT_W){1'b0}}, y};
  end

endmodule

// File: rtl/mlp_tile_engine.sv
// Tiled int8 MLP layer engine with LANES parallel MACs.
//   clk, rst              : clock, synchronous active-high reset
//   start                 : begin a layer (sampled in IDLE only)
//   mode, scaling_factor  : output format and requant multiplier (latched)
//   in_dim, out_dim       : layer dimensions (latched, validated at start)
//   in_valid/in_ready     : load stream handshake, data_in carries 4 bytes
//                           or one bias word
//   out_valid/out_ready   : result stream handshake, ofmap is the result
//   busy, done, err       : not-idle flag, end-of-layer pulse, bad-config pulse
module mlp_tile_engine
  import mlp_pkg::*;
#(
  parameter int LANES   = 8,
  parameter int MAX_IN  = 64,
  parameter int MAX_OUT = 64,
  parameter int SCALE_W = 12,
  parameter int SHIFT   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        mode,
  input  logic [SCALE_W-1:0]          scaling_factor,
  input  logic [$clog2(MAX_IN):0]     in_dim,
  input  logic [$clog2(MAX_OUT):0]    out_dim,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [31:0]                 data_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [31:0]                 ofmap,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  localparam int IN_W  = $clog2(MAX_IN) + 1;
  localparam int OUT_W = $clog2(MAX_OUT) + 1;
  localparam int KW    = $clog2(MAX_IN);
  localparam int OW    = $clog2(MAX_OUT);
  localparam int ROWS  = (MAX_OUT / LANES) * MAX_IN;
  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(MAX_OUT * MAX_IN / 4) + 1;
  localparam int LW    = $clog2(LANES);
  localparam int GRPS  = LANES / 4;
  localparam int GW    = (GRPS > 1) ? $clog2(GRPS) : 1;
  localparam int PRW   = IN_W + OUT_W;

  // Storage; contents are only meaningful after a full reload.
  logic signed [ACT_W-1:0]       x_mem [MAX_IN];
  logic        [LANES*ACT_W-1:0] w_mem [ROWS];
  logic signed [ACC_W-1:0]       b_mem [MAX_OUT];

  state_e                  state_q;
  logic                    mode_q;
  logic [SCALE_W-1:0]      scale_q;
  logic [IN_W-1:0]         in_dim_q;
  logic [OUT_W-1:0]        out_dim_q;
  logic [CW-1:0]           wlast_q;
  logic [CW-1:0]           cnt_q;
  logic [GW-1:0]           grp_q;
  logic [RW-1:0]           wrow_q;
  logic [KW-1:0]           k_q;
  logic [LW-1:0]           lane_q;
  logic [OUT_W-1:0]        obase_q;
  logic signed [ACC_W-1:0] acc_q [LANES];
  logic                    in_ready_q, out_valid_q, busy_q, done_q, err_q;
  logic [31:0]             ofmap_q;

  logic                    load_hs, cfg_bad;
  logic                    x_last, w_last, b_last, grp_last, k_last, lane_last, tile_last;
  logic [CW-1:0]           wlast_d;
  logic [LANES*ACT_W-1:0]  w_row;
  logic signed [ACT_W-1:0] x_cur;
  logic signed [ACT_W-1:0] w_lane [LANES];
  logic signed [ACC_W-1:0] acc_d [LANES];
  logic [LW-1:0]           sel;
  logic signed [ACC_W-1:0] rq_acc;
  logic [31:0]             rq_word;

  always_comb begin
    load_hs   = in_valid && in_ready_q;
    cfg_bad   = (in_dim == '0) || (in_dim[1:0] != 2'b00) || (in_dim > IN_W'(MAX_IN)) ||
                (out_dim == '0) || ((out_dim % OUT_W'(LANES)) != '0) ||
                (out_dim > OUT_W'(MAX_OUT));
    // Weight word count is (in_dim/4)*out_dim; in_dim is a multiple of 4 here.
    wlast_d   = CW'(PRW'(in_dim[IN_W-1:2]) * PRW'(out_dim)) - CW'(1);
    x_last    = cnt_q == (CW'(in_dim_q >> 2) - CW'(1));
    w_last    = cnt_q == wlast_q;
    b_last    = cnt_q == (CW'(out_dim_q) - CW'(1));
    grp_last  = grp_q == GW'(GRPS - 1);
    k_last    = k_q == KW'(in_dim_q - IN_W'(1));
    lane_last = lane_q == LW'(LANES - 1);
    tile_last = (obase_q + OUT_W'(LANES)) == out_dim_q;

    w_row = w_mem[wrow_q];
    x_cur = x_mem[k_q];
    for (int l = 0; l < LANES; l++) begin
      w_lane[l] = w_row[ACT_W*l +: ACT_W];
      acc_d[l]  = acc_q[l] + ACC_W'(x_cur) * ACC_W'(w_lane[l]);
    end

    // Requantiser looks one lane ahead so the next word is ready at the handshake.
    sel    = (out_valid_q && !lane_last) ? lane_q + LW'(1) : '0;
    rq_acc = acc_q[sel];
  end

  mlp_requant #(
    .SCALE_W (SCALE_W),
    .SHIFT   (SHIFT)
  ) u_requant (
    .acc_i   (rq_acc),
    .scale_i (scale_q),
    .mode_i  (mode_q),
    .ofmap_o (rq_word)
  );

  // Load stream into storage; one weight row holds all lanes for a (tile, k).
  always_ff @(posedge clk) begin
    if (load_hs) begin
      case (state_q)
        LOAD_X: begin
          for (int b = 0; b < 4; b++) begin
            x_mem[KW'({cnt_q, 2'b00}) + KW'(b)] <= data_in[8*b +: 8];
          end
        end
        LOAD_W:  w_mem[wrow_q][32*grp_q +: 32] <= data_in;
        LOAD_B:  b_mem[OW'(cnt_q)] <= data_in;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      scale_q     <= '0;
      in_dim_q    <= '0;
      out_dim_q   <= '0;
      wlast_q     <= '0;
      cnt_q       <= '0;
      grp_q       <= '0;
      wrow_q      <= '0;
      k_q         <= '0;
      lane_q      <= '0;
      obase_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      ofmap_q     <= '0;
      for (int l = 0; l < LANES; l++) acc_q[l] <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (cfg_bad) begin
              err_q <= 1'b1;
            end else begin
              mode_q     <= mode;
              scale_q    <= scaling_factor;
              in_dim_q   <= in_dim;
              out_dim_q  <= out_dim;
              wlast_q    <= wlast_d;
              cnt_q      <= '0;
              grp_q      <= '0;
              wrow_q     <= '0;
              in_ready_q <= 1'b1;
              busy_q     <= 1'b1;
              state_q    <= LOAD_X;
            end
          end
        end
        LOAD_X: begin
          if (load_hs) begin
            if (x_last) begin
              cnt_q   <= '0;
              state_q <= LOAD_W;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        LOAD_W: begin
          if (load_hs) begin
            if (grp_last) begin
              grp_q  <= '0;
              wrow_q <= wrow_q + RW'(1);
            end else begin
              grp_q <= grp_q + GW'(1);
            end
            if (w_last) begin
              cnt_q   <= '0;
              state_q <= LOAD_B;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        LOAD_B: begin
          if (load_hs) begin
            if (b_last) begin
              cnt_q      <= '0;
              in_ready_q <= 1'b0;
              obase_q    <= '0;
              wrow_q     <= '0;
              state_q    <= BIAS;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        // Tile start: seed accumulators with this tile's biases.
        BIAS: begin
          for (int l = 0; l < LANES; l++) begin
            acc_q[l] <= b_mem[OW'(obase_q + OUT_W'(l))];
          end
          k_q     <= '0;
          state_q <= MAC;
        end
        // Weight rows run contiguously across tiles, so wrow_q never rewinds.
        MAC: begin
          for (int l = 0; l < LANES; l++) acc_q[l] <= acc_d[l];
          wrow_q <= wrow_q + RW'(1);
          k_q    <= k_q + KW'(1);
          if (k_last) begin
            lane_q  <= '0;
            state_q <= DRAIN;
          end
        end
        // First DRAIN cycle only registers lane 0; afterwards one lane per handshake.
        DRAIN: begin
          if (!out_valid_q) begin
            ofmap_q     <= rq_word;
            out_valid_q <= 1'b1;
            lane_q      <= '0;
          end else if (out_ready) begin
            if (lane_last) begin
              out_valid_q <= 1'b0;
              if (tile_last) begin
                done_q  <= 1'b1;
                state_q <= DONE;
              end else begin
                obase_q <= obase_q + OUT_W'(LANES);
                state_q <= BIAS;
              end
            end else begin
              lane_q  <= lane_q + LW'(1);
              ofmap_q <= rq_word;
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign ofmap     = ofmap_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mlp_tile_engine.sv
// Directed testbench for mlp_tile_engine.
module tb_mlp_tile_engine;

  localparam int LANES   = 8;
  localparam int MAX_IN  = 64;
  localparam int MAX_OUT = 64;
  localparam int SCALE_W = 12;
  localparam int SHIFT   = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic               mode = 1'b0;
  logic [SCALE_W-1:0] scaling_factor = '0;
  logic [6:0]         in_dim = '0;
  logic [6:0]         out_dim = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [31:0]        data_in = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [31:0]        ofmap;
  logic               busy, done, err;

  mlp_tile_engine #(
    .LANES(LANES), .MAX_IN(MAX_IN), .MAX_OUT(MAX_OUT), .SCALE_W(SCALE_W), .SHIFT(SHIFT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .scaling_factor(scaling_factor),
    .in_dim(in_dim), .out_dim(out_dim), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready), .ofmap(ofmap),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          xv [MAX_IN];
  int          wv [MAX_OUT][MAX_IN];
  int          bv [MAX_OUT];
  logic [31:0] got [MAX_OUT];
  int          n_got;
  int          words_sent;

  // Reference: bias + dot product with 32-bit wrap, then round/ReLU/saturate.
  function automatic logic [31:0] model(input int o, input logic m, input int sc, input int ind);
    int     acc;
    longint p, r;
    acc = bv[o];
    for (int k = 0; k < ind; k++) acc += xv[k] * wv[o][k];
    if (m) return 32'(acc);
    p = longint'(acc) * longint'(sc);
    r = (p + 64'sd128) >>> SHIFT;
    if (r < 0) return '0;
    if (r > 127) return 32'd127;
    return 32'(r);
  endfunction

  task automatic clear_data();
    for (int i = 0; i < MAX_IN; i++) xv[i] = 0;
    for (int o = 0; o < MAX_OUT; o++) begin
      bv[o] = 0;
      for (int k = 0; k < MAX_IN; k++) wv[o][k] = 0;
    end
  endtask

  task automatic basic_data(input int bias);
    clear_data();
    for (int i = 0; i < 4; i++) xv[i] = i + 1;
    for (int o = 0; o < 8; o++) begin
      bv[o] = bias;
      for (int k = 0; k < 4; k++) wv[o][k] = o;
    end
  endtask

  // All tasks enter and leave 1 time unit after a rising edge.
  task automatic do_start(input logic m, input int sc, input int ind, input int outd);
    mode = m;
    scaling_factor = SCALE_W'(sc);
    in_dim = 7'(ind);
    out_dim = 7'(outd);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble the config to show it was latched.
    mode = ~m;
    scaling_factor = '0;
    in_dim = 7'd6;
    out_dim = 7'd3;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    logic hs;
    int   guard;
    if (gaps && ($urandom_range(1, 0) == 1)) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    data_in = w;
    guard = 0;
    hs = 1'b0;
    while (!hs && guard < 100) begin
      hs = in_ready;
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    if (hs) begin
      words_sent++;
    end else begin
      checks++;
      failures++;
      $display("FAIL load_timeout in_ready=%0b required=1", in_ready);
    end
  endtask

  task automatic load_layer(input int ind, input int outd, input bit gaps);
    logic [31:0] wd;
    words_sent = 0;
    for (int i = 0; i < ind / 4; i++) begin
      for (int b = 0; b < 4; b++) wd[8*b +: 8] = 8'(xv[4*i+b]);
      send_word(wd, gaps);
    end
    for (int t = 0; t < outd / LANES; t++)
      for (int k = 0; k < ind; k++)
        for (int g = 0; g < LANES / 4; g++) begin
          for (int b = 0; b < 4; b++) wd[8*b +: 8] = 8'(wv[t*LANES+4*g+b][k]);
          send_word(wd, gaps);
        end
    for (int o = 0; o < outd; o++) send_word(32'(bv[o]), gaps);
  endtask

  task automatic collect(input int outd, input bit rand_ready);
    int          cyc;
    bit          stalled, early_done, hs;
    logic [31:0] held;
    n_got = 0; cyc = 0; stalled = 0; early_done = 0; held = '0;
    while (n_got < outd && cyc < 5000) begin
      out_ready = rand_ready ? 1'($urandom_range(1, 0)) : 1'b1;
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || ofmap !== held) begin
          failures++;
          $display("FAIL stall_hold valid=%0b ofmap=%08h required valid=1 ofmap=%08h",
                   out_valid, ofmap, held);
        end
      end
      if (done === 1'b1) early_done = 1;
      hs = (out_valid === 1'b1) && out_ready;
      stalled = (out_valid === 1'b1) && !out_ready;
      held = ofmap;
      if (hs) begin
        got[n_got] = ofmap;
        n_got++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b1;
    checks++;
    if (n_got != outd) begin
      failures++;
      $display("FAIL out_count got=%0d required=%0d", n_got, outd);
    end
    checks++;
    if (done !== 1'b1 || early_done) begin
      failures++;
      $display("FAIL done_pulse done=%0b early=%0b required done=1 early=0", done, early_done);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL after_done done=%0b busy=%0b required 0 0", done, busy);
    end
  endtask

  task automatic run_layer(input logic m, input int sc, input int ind, input int outd,
                           input bit gaps, input bit rr);
    do_start(m, sc, ind, outd);
    load_layer(ind, outd, gaps);
    collect(outd, rr);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, busy, done, err} !== 5'b0 || ofmap !== 32'h0) begin
      failures++;
      $display("FAIL reset_state flags=%05b ofmap=%08h required 00000 0",
               {in_ready, out_valid, busy, done, err}, ofmap);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int e [8];
    basic_data(0);
    do_start(1'b1, 0, 4, 8);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1 || err !== 1'b0) begin
      failures++;
      $display("FAIL basic_start busy=%0b in_ready=%0b err=%0b required 1 1 0", busy, in_ready, err);
    end
    load_layer(4, 8, 0);
    collect(8, 0);
    for (int o = 0; o < 8; o++) begin
      checks++;
      if (got[o] !== 32'(o * 10)) begin
        failures++;
        $display("FAIL basic_raw[%0d] got=%08h required=%08h", o, got[o], 32'(o * 10));
      end
    end
    basic_data(-50);
    run_layer(1'b0, 256, 4, 8, 0, 1);
    e = '{0, 0, 0, 0, 0, 0, 10, 20};
    for (int o = 0; o < 8; o++) begin
      checks++;
      if (got[o] !== 32'(e[o])) begin
        failures++;
        $display("FAIL basic_requant[%0d] got=%08h required=%08h", o, got[o], 32'(e[o]));
      end
    end
  endtask

  task automatic test_requant_edges();
    int e [8];
    // x = [1,0,0,0] and zero weights, so each accumulator equals its bias.
    clear_data();
    xv[0] = 1;
    bv[0:7] = '{3, -3, 1000, -1000, 1, 5, -1, 200};
    run_layer(1'b0, 128, 4, 8, 0, 0);
    e = '{2, 0, 127, 0, 1, 3, 0, 100};
    for (int o = 0; o < 8; o++) begin
      checks++;
      if (got[o] !== 32'(e[o])) begin
        failures++;
        $display("FAIL rq_scale128[%0d] got=%08h required=%08h", o, got[o], 32'(e[o]));
      end
    end
    bv[0:7] = '{1000, 127, 128, -128, 0, 126, 32'h7fffffff, 64};
    run_layer(1'b0, 256, 4, 8, 0, 0);
    e = '{127, 127, 127, 0, 0, 126, 127, 64};
    for (int o = 0; o < 8; o++) begin
      checks++;
      if (got[o] !== 32'(e[o])) begin
        failures++;
        $display("FAIL rq_scale256[%0d] got=%08h required=%08h", o, got[o], 32'(e[o]));
      end
    end
    // Lane 1: 0x7fffffff + 1*1 wraps to 0x80000000.
    wv[1][0] = 1;
    bv[0:7] = '{32'h80000000, 32'h7fffffff, -1, 0, 5, -5, 100, 123};
    run_layer(1'b1, 0, 4, 8, 0, 0);
    e = '{32'h80000000, 32'h80000000, 32'hffffffff, 0, 5, 32'hfffffffb, 100, 123};
    for (int o = 0; o < 8; o++) begin
      checks++;
      if (got[o] !== 32'(e[o])) begin
        failures++;
        $display("FAIL rq_raw[%0d] got=%08h required=%08h", o, got[o], 32'(e[o]));
      end
    end
  endtask

  task automatic test_two_tiles();
    logic [31:0] m;
    for (int k = 0; k < 64; k++) xv[k] = int'($urandom_range(255, 0)) - 128;
    for (int o = 0; o < 16; o++) begin
      bv[o] = int'($urandom_range(2000, 0)) - 1000;
      for (int k = 0; k < 64; k++) wv[o][k] = int'($urandom_range(255, 0)) - 128;
    end
    run_layer(1'b1, 0, 64, 16, 0, 1);
    for (int o = 0; o < 16; o++) begin
      m = model(o, 1'b1, 0, 64);
      checks++;
      if (got[o] !== m) begin
        failures++;
        $display("FAIL tiles_raw[%0d] got=%08h required=%08h", o, got[o], m);
      end
    end
    run_layer(1'b0, 3, 64, 16, 0, 1);
    for (int o = 0; o < 16; o++) begin
      m = model(o, 1'b0, 3, 64);
      checks++;
      if (got[o] !== m) begin
        failures++;
        $display("FAIL tiles_requant[%0d] got=%08h required=%08h", o, got[o], m);
      end
    end
  endtask

  task automatic test_config_errors();
    int bad_in [6];
    int bad_out [6];
    bad_in  = '{6, 4, 0, 68, 4, 4};
    bad_out = '{8, 12, 8, 8, 0, 72};
    for (int i = 0; i < 6; i++) begin
      do_start(1'b0, 256, bad_in[i], bad_out[i]);
      checks++;
      if (err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL cfg_err[%0d] err=%0b busy=%0b in_ready=%0b required 1 0 0",
                 i, err, busy, in_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (err !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL cfg_err_after[%0d] err=%0b busy=%0b in_ready=%0b required 0 0 0",
                 i, err, busy, in_ready);
      end
    end
  endtask

  task automatic test_load_backpressure();
    // Stray load words while idle must be ignored.
    in_valid = 1'b1;
    data_in = 32'hdeadbeef;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready !== 1'b0) begin
        failures++;
        $display("FAIL idle_in_ready got=%0b required=0", in_ready);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    basic_data(0);
    do_start(1'b1, 0, 4, 8);
    load_layer(4, 8, 1);
    // in_dim/4 + out_dim*in_dim/4 + out_dim words.
    checks++;
    if (words_sent != 17 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL load_words got=%0d in_ready=%0b required=17 0", words_sent, in_ready);
    end
    collect(8, 1);
    for (int o = 0; o < 8; o++) begin
      checks++;
      if (got[o] !== 32'(o * 10)) begin
        failures++;
        $display("FAIL gapped[%0d] got=%08h required=%08h", o, got[o], 32'(o * 10));
      end
    end
  endtask

  task automatic test_reset_mid();
    int  cnt, cyc;
    bit  seen;
    do_start(1'b1, 0, 64, 16);
    load_layer(64, 16, 0);
    out_ready = 1'b1;
    cnt = 0; cyc = 0;
    while (cnt < 8 && cyc < 500) begin
      if (out_valid === 1'b1) cnt++;
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cnt != 8) begin
      failures++;
      $display("FAIL tile0_outputs got=%0d required=8", cnt);
    end
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, busy, done, err} !== 5'b0 || ofmap !== 32'h0) begin
      failures++;
      $display("FAIL midreset_state flags=%05b ofmap=%08h required 00000 0",
               {in_ready, out_valid, busy, done, err}, ofmap);
    end
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      if (done === 1'b1 || out_valid === 1'b1 || busy === 1'b1) seen = 1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL midreset_quiet activity=%0b required=0", seen);
    end
    basic_data(0);
    run_layer(1'b1, 0, 4, 8, 0, 0);
    for (int o = 0; o < 8; o++) begin
      checks++;
      if (got[o] !== 32'(o * 10)) begin
        failures++;
        $display("FAIL post_reset[%0d] got=%08h required=%08h", o, got[o], 32'(o * 10));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_requant_edges();
    test_two_tiles();
    test_config_errors();
    test_load_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
